// File: rtl/change_return_ctrl.sv
// change_return_ctrl: breaks a change amount into high/low coin issues, one coin
// per ack handshake, tracking coin stock and reporting any undelivered remainder.
module change_return_ctrl #(
    parameter int unsigned COIN_HI    = 5,
    parameter int unsigned COIN_LO    = 1,
    parameter int unsigned STOCK_INIT = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned ACK_TO     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic [7:0] amount_i,
    input  logic       coin_ack_i,
    input  logic       refill_hi_i,
    input  logic       refill_lo_i,
    output logic [3:0] ret_val_o,
    output logic       ret_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] rem_out_o,
    output logic [3:0] stock_hi_o,
    output logic [3:0] stock_lo_o
);

    localparam int unsigned TO_W  = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       ret_val_q, ret_val_d;
    logic             ret_en_q, ret_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       rem_q, rem_d;
    logic [3:0]       stock_hi_q, stock_hi_d;
    logic [3:0]       stock_lo_q, stock_lo_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             dec_hi, dec_lo;

    // Next-state and next-output logic for the dispense sequencer
    always_comb begin
        state_d    = state_q;
        ret_val_d  = ret_val_q;
        ret_en_d   = ret_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rem_d      = rem_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        dec_hi     = 1'b0;
        dec_lo     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    rem_d   = amount_i;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rem_q >= 8'(COIN_HI) && stock_hi_q != 4'd0) begin
                    ret_en_d  = 1'b1;
                    ret_val_d = 4'(COIN_HI);
                    to_cnt_d  = '0;
                    state_d   = S_ISSUE;
                end else if (rem_q >= 8'(COIN_LO) && stock_lo_q != 4'd0) begin
                    ret_en_d  = 1'b1;
                    ret_val_d = 4'(COIN_LO);
                    to_cnt_d  = '0;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_ISSUE: begin
                if (coin_ack_i) begin
                    rem_d     = rem_q - 8'(ret_val_q);
                    dec_hi    = (ret_val_q == 4'(COIN_HI));
                    dec_lo    = (ret_val_q != 4'(COIN_HI));
                    ret_en_d  = 1'b0;
                    ret_val_d = 4'd0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
                end else if (to_cnt_q == TO_W'(ACK_TO - 1)) begin
                    ret_en_d  = 1'b0;
                    ret_val_d = 4'd0;
                    state_d   = S_FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stock bookkeeping: saturating refill, coincident refill and issue cancel
    always_comb begin
        stock_hi_d = stock_hi_q;
        stock_lo_d = stock_lo_q;
        if (refill_hi_i && !dec_hi) begin
            if (stock_hi_q != 4'hF) stock_hi_d = stock_hi_q + 4'd1;
        end else if (dec_hi && !refill_hi_i) begin
            if (stock_hi_q != 4'd0) stock_hi_d = stock_hi_q - 4'd1;
        end
        if (refill_lo_i && !dec_lo) begin
            if (stock_lo_q != 4'hF) stock_lo_d = stock_lo_q + 4'd1;
        end else if (dec_lo && !refill_lo_i) begin
            if (stock_lo_q != 4'd0) stock_lo_d = stock_lo_q - 4'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ret_val_q  <= 4'd0;
            ret_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rem_q      <= 8'd0;
            stock_hi_q <= 4'(STOCK_INIT);
            stock_lo_q <= 4'(STOCK_INIT);
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_val_q  <= ret_val_d;
            ret_en_q   <= ret_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rem_q      <= rem_d;
            stock_hi_q <= stock_hi_d;
            stock_lo_q <= stock_lo_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ret_val_o  = ret_val_q;
    assign ret_en_o   = ret_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rem_out_o  = rem_q;
    assign stock_hi_o = stock_hi_q;
    assign stock_lo_o = stock_lo_q;

endmodule

// File: tb/tb_change_return_ctrl.sv
// Directed self-checking bench for change_return_ctrl (default and empty-stock instances).
module tb_change_return_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req, coin_ack, refill_hi, refill_lo;
    logic [7:0] amount;
    logic [3:0] ret_val, stock_hi, stock_lo;
    logic       ret_en, busy, done, err;
    logic [7:0] rem_out;

    logic       req0, coin_ack0, refill_hi0, refill_lo0;
    logic [7:0] amount0;
    logic [3:0] ret_val0, stock_hi0, stock_lo0;
    logic       ret_en0, busy0, done0, err0;
    logic [7:0] rem_out0;

    int checks = 0;
    int errors = 0;

    change_return_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .amount_i   (amount),
        .coin_ack_i (coin_ack),
        .refill_hi_i(refill_hi),
        .refill_lo_i(refill_lo),
        .ret_val_o  (ret_val),
        .ret_en_o   (ret_en),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .rem_out_o  (rem_out),
        .stock_hi_o (stock_hi),
        .stock_lo_o (stock_lo)
    );

    change_return_ctrl #(.STOCK_INIT(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req0),
        .amount_i   (amount0),
        .coin_ack_i (coin_ack0),
        .refill_hi_i(refill_hi0),
        .refill_lo_i(refill_lo0),
        .ret_val_o  (ret_val0),
        .ret_en_o   (ret_en0),
        .busy_o     (busy0),
        .done_o     (done0),
        .err_o      (err0),
        .rem_out_o  (rem_out0),
        .stock_hi_o (stock_hi0),
        .stock_lo_o (stock_lo0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for a coin on u_dut, ack it after ack_delay cycles, optionally with a coincident refill_hi
    task automatic serve_coin(input int ack_delay, input bit refill_too,
                              output logic [3:0] val, output int waited);
        waited = 0;
        while (!ret_en && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("coin_seen", 32'(ret_en), 32'd1);
        val = ret_val;
        repeat (ack_delay) begin
            @(negedge clk);
            check("coin_hold", {27'd0, ret_en, ret_val}, {27'd0, 1'b1, val});
        end
        coin_ack  = 1'b1;
        refill_hi = refill_too;
        @(negedge clk);
        coin_ack  = 1'b0;
        refill_hi = 1'b0;
        check("coin_drop", {27'd0, ret_en, ret_val}, 32'd0);
    endtask

    // Wait for the done pulse on u_dut; returns number of cycles waited
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    int         exp_val[4]  = '{5, 5, 1, 1};
    int         exp_wait[4] = '{1, 3, 3, 3};
    logic [3:0] v;
    int         w, n;

    initial begin
        rst_n = 1'b0; req = 1'b0; amount = 8'd0; coin_ack = 1'b0; refill_hi = 1'b0; refill_lo = 1'b0;
        req0 = 1'b0; amount0 = 8'd0; coin_ack0 = 1'b0; refill_hi0 = 1'b0; refill_lo0 = 1'b0;
        repeat (2) @(negedge clk);

        // T1: reset state
        check("t1_outputs", {15'd0, ret_val, ret_en, busy, done, err, rem_out}, 32'd0);
        check("t1_stock_hi", 32'(stock_hi), 32'd8);
        check("t1_stock_lo", 32'(stock_lo), 32'd8);
        check("t1_stock0", {24'd0, stock_hi0, stock_lo0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T3: empty stock, three low coins refilled, amount 7 -> fault with remainder 4
        repeat (3) begin
            refill_lo0 = 1'b1;
            @(negedge clk);
            refill_lo0 = 1'b0;
            @(negedge clk);
        end
        check("t3_refilled", 32'(stock_lo0), 32'd3);
        amount0 = 8'd7; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!ret_en0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("t3_coin", {27'd0, ret_en0, ret_val0}, {27'd0, 1'b1, 4'd1});
            coin_ack0 = 1'b1;
            @(negedge clk);
            coin_ack0 = 1'b0;
            check("t3_drop", 32'(ret_en0), 32'd0);
        end
        n = 0;
        while (!err0 && n < 20) begin
            @(negedge clk);
            n++;
            check("t3_no_coin", 32'(ret_en0), 32'd0);
        end
        check("t3_err", 32'(err0), 32'd1);
        check("t3_busy", 32'(busy0), 32'd0);
        check("t3_rem", 32'(rem_out0), 32'd4);
        check("t3_stock", {24'd0, stock_hi0, stock_lo0}, 32'd0);

        // T2: amount 12 -> 5,5,1,1, ack one cycle after each strobe
        @(negedge clk);
        amount = 8'd12; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            serve_coin(1, 1'b0, v, w);
            check("t2_coin_val", 32'(v), 32'(exp_val[i]));
            check("t2_coin_wait", 32'(w), 32'(exp_wait[i]));
        end
        wait_done(n);
        check("t2_done_lat", 32'(n), 32'd3);
        check("t2_rem", 32'(rem_out), 32'd0);
        check("t2_stock_hi", 32'(stock_hi), 32'd6);
        check("t2_stock_lo", 32'(stock_lo), 32'd6);
        @(negedge clk);
        check("t2_done_pulse", {30'd0, done, busy}, 32'd0);

        // T4: amount 5, never acked -> 16 strobe cycles then fault
        amount = 8'd5; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!ret_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_coin", {27'd0, ret_en, ret_val}, {27'd0, 1'b1, 4'd5});
        w = 0;
        while (ret_en && w < 40) begin
            w++;
            @(negedge clk);
        end
        check("t4_en_cycles", 32'(w), 32'd16);
        @(negedge clk);
        check("t4_err", 32'(err), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rem", 32'(rem_out), 32'd5);
        check("t4_stock_hi", 32'(stock_hi), 32'd6);

        // T5: stray ack in IDLE ignored; refill coincident with high-coin ack; req while busy ignored
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        @(negedge clk);
        check("t5_stray_ack", {24'd0, stock_hi, stock_lo}, {24'd0, 4'd6, 4'd6});
        check("t5_err_sticky", 32'(err), 32'd1);
        amount = 8'd5; req = 1'b1;
        @(negedge clk);
        check("t5_err_clear", 32'(err), 32'd0);
        check("t5_rem_load", 32'(rem_out), 32'd5);
        amount = 8'd99;
        @(negedge clk);
        req = 1'b0;
        serve_coin(2, 1'b1, v, w);
        check("t5_coin_val", 32'(v), 32'd5);
        check("t5_stock_hi_net", 32'(stock_hi), 32'd6);
        wait_done(n);
        check("t5_rem", 32'(rem_out), 32'd0);
        repeat (20) begin
            @(negedge clk);
            refill_hi = 1'b1;
            @(negedge clk);
            refill_hi = 1'b0;
        end
        check("t5_stock_sat", 32'(stock_hi), 32'd15);
        check("t5_stock_lo", 32'(stock_lo), 32'd6);

        // T6: amount 0 -> done two cycles after req, no coin
        @(negedge clk);
        amount = 8'd0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("t6_c1", {29'd0, ret_en, done, busy}, 32'd1);
        @(negedge clk);
        check("t6_c2", {29'd0, ret_en, done, busy}, 32'd3);
        @(negedge clk);
        check("t6_c3", {29'd0, ret_en, done, busy}, 32'd0);

        // Reset asserted mid-ISSUE: strobe drops at once, stock reloads
        amount = 8'd3; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_pre_coin", {27'd0, ret_en, ret_val}, {27'd0, 1'b1, 4'd1});
        #2 rst_n = 1'b0;
        #1;
        check("rst_en_async", 32'(ret_en), 32'd0);
        check("rst_outputs", {15'd0, ret_val, ret_en, busy, done, err, rem_out}, 32'd0);
        check("rst_stock", {24'd0, stock_hi, stock_lo}, {24'd0, 4'd8, 4'd8});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        amount = 8'd0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_idle_done", {29'd0, ret_en, done, busy}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
